// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - instruction fetch controller with request FSM and instruction buffer
module if_fetch_ctrl #(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INST   = 32'h00000013
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] pc_i,
   input  logic        redirect_i,
   output logic        pc_hold_o,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        id_valid_o,
   output logic [31:0] id_inst_o,
   output logic [31:0] id_pc_o,
   input  logic        id_ready_i
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_GNT = 2'd1,
      WAIT_RSP = 2'd2,
      DROP     = 2'd3
   } state_t;

   state_t           state_q;
   logic             req_q;
   logic [31:0]      req_pc_q;
   logic [31:0]      buf_pc_q   [FIFO_DEPTH];
   logic [31:0]      buf_inst_q [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [CNT_W-1:0] count_q;

   logic rsp_done;
   logic push;
   logic pop;

   // A response completes either in WAIT_RSP or together with the grant (0-wait memory)
   assign rsp_done = ((state_q == WAIT_GNT) && imem_gnt_i && imem_rvalid_i) ||
                     ((state_q == WAIT_RSP) && imem_rvalid_i);
   assign push     = rsp_done && !redirect_i;
   assign pop      = id_valid_o && id_ready_i && !redirect_i;

   assign imem_req_o  = req_q;
   assign imem_addr_o = req_pc_q;
   assign pc_hold_o   = !((req_q && imem_gnt_i) || redirect_i);
   assign id_valid_o  = (count_q != '0);
   assign id_inst_o   = id_valid_o ? buf_inst_q[rd_ptr_q] : NOP_INST;
   assign id_pc_o     = id_valid_o ? buf_pc_q[rd_ptr_q]   : 32'h0;

   // Request FSM: one outstanding request, redirect flushes or drops the in-flight fetch
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         req_pc_q <= 32'h0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!redirect_i && (count_q < DEPTH_C)) begin
                  req_pc_q <= pc_i & 32'hFFFF_FFFC;
                  req_q    <= 1'b1;
                  state_q  <= WAIT_GNT;
               end
            end
            WAIT_GNT: begin
               if (imem_gnt_i) begin
                  req_q <= 1'b0;
                  if (imem_rvalid_i)   state_q <= IDLE;
                  else if (redirect_i) state_q <= DROP;
                  else                 state_q <= WAIT_RSP;
               end else if (redirect_i) begin
                  req_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            WAIT_RSP: begin
               if (imem_rvalid_i)   state_q <= IDLE;
               else if (redirect_i) state_q <= DROP;
            end
            DROP: begin
               if (imem_rvalid_i) state_q <= IDLE;
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Buffer bookkeeping: redirect clears everything and overrides any same-cycle pop
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else if (redirect_i) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_q <= count_q + CNT_W'(1);
         else if (!push && pop) count_q <= count_q - CNT_W'(1);
      end
   end

   // Buffer storage: returned instruction paired with the PC it was fetched from
   always_ff @(posedge clk_i) begin
      if (push) begin
         buf_pc_q[wr_ptr_q]   <= req_pc_q;
         buf_inst_q[wr_ptr_q] <= imem_rdata_i;
      end
   end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - directed self-checking bench for if_fetch_ctrl
`timescale 1ns/1ps
module tb_if_fetch_ctrl;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk_i;
   logic        rst_i;
   logic [31:0] pc_i;
   logic        redirect_i;
   logic        pc_hold_o;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        id_valid_o;
   logic [31:0] id_inst_o;
   logic [31:0] id_pc_o;
   logic        id_ready_i;

   int          n_checks = 0;
   int          n_fail   = 0;
   bit          auto_mem;
   logic [31:0] redirect_pc;
   logic [31:0] gnt_addr_q[$];
   logic [31:0] pop_pc_q[$];
   logic [31:0] pop_inst_q[$];
   int          hold0_cnt;

   if_fetch_ctrl #(.FIFO_DEPTH(2), .NOP_INST(NOP)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .redirect_i(redirect_i),
      .pc_hold_o(pc_hold_o), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .id_valid_o(id_valid_o), .id_inst_o(id_inst_o), .id_pc_o(id_pc_o), .id_ready_i(id_ready_i)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   task automatic clear_logs();
      gnt_addr_q.delete();
      pop_pc_q.delete();
      pop_inst_q.delete();
      hold0_cnt = 0;
   endtask

   // One clock: log handshakes mid-cycle, then emulate the PC register and optional 0-wait memory
   task automatic tick();
      logic hold, redir;
      #3;
      hold  = pc_hold_o;
      redir = redirect_i;
      if (imem_req_o && imem_gnt_i) gnt_addr_q.push_back(imem_addr_o);
      if (!hold) hold0_cnt++;
      if (id_valid_o && id_ready_i && !redir) begin
         pop_pc_q.push_back(id_pc_o);
         pop_inst_q.push_back(id_inst_o);
      end
      @(posedge clk_i);
      #1;
      if (rst_i)      pc_i = 32'h0;
      else if (redir) pc_i = redirect_pc;
      else if (!hold) pc_i = pc_i + 32'd4;
      if (auto_mem) begin
         imem_gnt_i    = imem_req_o;
         imem_rvalid_i = imem_req_o;
         imem_rdata_i  = mem_data(imem_addr_o);
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b1; auto_mem = 1'b0; redirect_i = 1'b0; redirect_pc = 32'h0;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
      id_ready_i = 1'b0; pc_i = 32'h0;
      tick();
      tick();
      rst_i = 1'b0;
      clear_logs();
   endtask

   task automatic test_reset();
      rst_i = 1'b1; auto_mem = 1'b0; redirect_i = 1'b0; redirect_pc = 32'h0;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
      id_ready_i = 1'b0; pc_i = 32'h0;
      clear_logs();
      tick();
      #1;
      n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", imem_req_o); end
      n_checks++; if (imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", imem_addr_o); end
      n_checks++; if (id_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", id_valid_o); end
      n_checks++; if (id_inst_o !== NOP) begin n_fail++; $display("FAIL rst_inst: got %h expected %h", id_inst_o, NOP); end
      n_checks++; if (id_pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h expected 0", id_pc_o); end
      n_checks++; if (pc_hold_o !== 1'b1) begin n_fail++; $display("FAIL rst_hold: got %b expected 1", pc_hold_o); end
      tick();
      rst_i = 1'b0;
      #1;
      n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_first_cycle_req: got %b expected 0", imem_req_o); end
      tick();
      #1;
      n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_second_cycle_req: got req=%b addr=%h expected req=1 addr=0", imem_req_o, imem_addr_o); end
   endtask

   task automatic test_zero_wait();
      do_reset();
      auto_mem = 1'b1; id_ready_i = 1'b1;
      for (int i = 0; i < 30 && pop_pc_q.size() < 4; i++) tick();
      n_checks++; if (pop_pc_q.size() < 4) begin n_fail++; $display("FAIL zw_pop_count: got %0d expected 4", pop_pc_q.size()); end
      for (int i = 0; i < 4 && i < pop_pc_q.size(); i++) begin
         n_checks++; if (pop_pc_q[i] !== 32'(4*i)) begin n_fail++; $display("FAIL zw_pop_pc[%0d]: got %h expected %h", i, pop_pc_q[i], 32'(4*i)); end
         n_checks++; if (pop_inst_q[i] !== mem_data(32'(4*i))) begin n_fail++; $display("FAIL zw_pop_inst[%0d]: got %h expected %h", i, pop_inst_q[i], mem_data(32'(4*i))); end
      end
      for (int i = 0; i < 4 && i < gnt_addr_q.size(); i++) begin
         n_checks++; if (gnt_addr_q[i] !== 32'(4*i)) begin n_fail++; $display("FAIL zw_gnt_addr[%0d]: got %h expected %h", i, gnt_addr_q[i], 32'(4*i)); end
      end
      n_checks++; if (hold0_cnt != gnt_addr_q.size()) begin n_fail++; $display("FAIL zw_hold_pulses: got %0d expected %0d", hold0_cnt, gnt_addr_q.size()); end
   endtask

   task automatic test_backpressure();
      do_reset();
      auto_mem = 1'b1; id_ready_i = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      #1;
      n_checks++; if (gnt_addr_q.size() != 2) begin n_fail++; $display("FAIL bp_fetch_count: got %0d expected 2", gnt_addr_q.size()); end
      n_checks++; if (hold0_cnt != 2) begin n_fail++; $display("FAIL bp_hold_pulses: got %0d expected 2", hold0_cnt); end
      n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL bp_req: got %b expected 0", imem_req_o); end
      n_checks++; if (pc_hold_o !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %b expected 1", pc_hold_o); end
      n_checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0 || id_inst_o !== mem_data(32'h0)) begin n_fail++; $display("FAIL bp_head: got v=%b pc=%h inst=%h expected v=1 pc=0 inst=%h", id_valid_o, id_pc_o, id_inst_o, mem_data(32'h0)); end
      id_ready_i = 1'b1;
      for (int i = 0; i < 10 && pop_pc_q.size() < 2; i++) tick();
      n_checks++; if (pop_pc_q.size() != 2) begin n_fail++; $display("FAIL bp_pops: got %0d expected 2", pop_pc_q.size()); end
      else begin
         n_checks++; if (pop_pc_q[0] !== 32'h0 || pop_pc_q[1] !== 32'h4) begin n_fail++; $display("FAIL bp_pop_order: got %h,%h expected 0,4", pop_pc_q[0], pop_pc_q[1]); end
      end
      for (int i = 0; i < 10 && gnt_addr_q.size() < 3; i++) tick();
      n_checks++; if (gnt_addr_q.size() < 3) begin n_fail++; $display("FAIL bp_resume: got %0d fetches expected 3", gnt_addr_q.size()); end
      else begin
         n_checks++; if (gnt_addr_q[2] !== 32'h8) begin n_fail++; $display("FAIL bp_resume_addr: got %h expected 8", gnt_addr_q[2]); end
      end
   endtask

   task automatic test_gnt_delay();
      int h0;
      do_reset();
      auto_mem = 1'b1; id_ready_i = 1'b1;
      for (int i = 0; i < 30 && gnt_addr_q.size() < 4; i++) tick();
      auto_mem = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
      h0 = hold0_cnt;
      tick();
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10 || pc_hold_o !== 1'b1) begin n_fail++; $display("FAIL gd_wait[%0d]: got req=%b addr=%h hold=%b expected req=1 addr=10 hold=1", i, imem_req_o, imem_addr_o, pc_hold_o); end
         tick();
      end
      imem_gnt_i = 1'b1;
      #1;
      n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10 || pc_hold_o !== 1'b0) begin n_fail++; $display("FAIL gd_gnt_cycle: got req=%b addr=%h hold=%b expected req=1 addr=10 hold=0", imem_req_o, imem_addr_o, pc_hold_o); end
      tick();
      imem_gnt_i = 1'b0;
      #1;
      n_checks++; if (imem_req_o !== 1'b0 || pc_hold_o !== 1'b1) begin n_fail++; $display("FAIL gd_wait_rsp: got req=%b hold=%b expected req=0 hold=1", imem_req_o, pc_hold_o); end
      imem_rvalid_i = 1'b1; imem_rdata_i = mem_data(32'h10);
      tick();
      imem_rvalid_i = 1'b0;
      #1;
      n_checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h10 || id_inst_o !== mem_data(32'h10)) begin n_fail++; $display("FAIL gd_head: got v=%b pc=%h inst=%h expected v=1 pc=10 inst=%h", id_valid_o, id_pc_o, id_inst_o, mem_data(32'h10)); end
      n_checks++; if (hold0_cnt - h0 != 1) begin n_fail++; $display("FAIL gd_hold_pulses: got %0d expected 1", hold0_cnt - h0); end
   endtask

   task automatic test_redirect_rsp();
      do_reset();
      pc_i = 32'h1C; auto_mem = 1'b1; id_ready_i = 1'b0;
      for (int i = 0; i < 10 && gnt_addr_q.size() < 1; i++) tick();
      auto_mem = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
      tick();
      imem_gnt_i = 1'b1;
      tick();
      imem_gnt_i = 1'b0;
      #1;
      n_checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h1C) begin n_fail++; $display("FAIL rr_pre_head: got v=%b pc=%h expected v=1 pc=1c", id_valid_o, id_pc_o); end
      redirect_i = 1'b1; redirect_pc = 32'h100;
      #1;
      n_checks++; if (pc_hold_o !== 1'b0) begin n_fail++; $display("FAIL rr_hold_on_redirect: got %b expected 0", pc_hold_o); end
      tick();
      redirect_i = 1'b0;
      #1;
      n_checks++; if (id_valid_o !== 1'b0 || imem_req_o !== 1'b0 || id_inst_o !== NOP) begin n_fail++; $display("FAIL rr_flush: got v=%b req=%b inst=%h expected v=0 req=0 inst=%h", id_valid_o, imem_req_o, id_inst_o, NOP); end
      imem_rvalid_i = 1'b1; imem_rdata_i = mem_data(32'h20);
      tick();
      imem_rvalid_i = 1'b0;
      #1;
      n_checks++; if (id_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rr_drop: got v=%b req=%b expected v=0 req=0", id_valid_o, imem_req_o); end
      id_ready_i = 1'b1; auto_mem = 1'b1;
      clear_logs();
      tick();
      #1;
      n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin n_fail++; $display("FAIL rr_next_req: got req=%b addr=%h expected req=1 addr=100", imem_req_o, imem_addr_o); end
      for (int i = 0; i < 10 && pop_pc_q.size() < 1; i++) tick();
      n_checks++; if (pop_pc_q.size() < 1) begin n_fail++; $display("FAIL rr_pop_timeout: got 0 pops expected 1"); end
      else begin
         n_checks++; if (pop_pc_q[0] !== 32'h100 || pop_inst_q[0] !== mem_data(32'h100)) begin n_fail++; $display("FAIL rr_first_pop: got pc=%h inst=%h expected pc=100 inst=%h", pop_pc_q[0], pop_inst_q[0], mem_data(32'h100)); end
      end
   endtask

   task automatic test_redirect_full();
      do_reset();
      auto_mem = 1'b1; id_ready_i = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      #1;
      n_checks++; if (id_valid_o !== 1'b1) begin n_fail++; $display("FAIL rf_pre_valid: got %b expected 1", id_valid_o); end
      auto_mem = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
      id_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc = 32'h200;
      tick();
      redirect_i = 1'b0;
      #1;
      n_checks++; if (id_valid_o !== 1'b0 || id_inst_o !== NOP || id_pc_o !== 32'h0) begin n_fail++; $display("FAIL rf_flush: got v=%b inst=%h pc=%h expected v=0 inst=%h pc=0", id_valid_o, id_inst_o, id_pc_o, NOP); end
      auto_mem = 1'b1;
      clear_logs();
      for (int i = 0; i < 10 && pop_pc_q.size() < 1; i++) tick();
      n_checks++; if (pop_pc_q.size() < 1) begin n_fail++; $display("FAIL rf_pop_timeout: got 0 pops expected 1"); end
      else begin
         n_checks++; if (pop_pc_q[0] !== 32'h200) begin n_fail++; $display("FAIL rf_first_pop: got %h expected 200", pop_pc_q[0]); end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      pc_i = 32'h40; auto_mem = 1'b1; id_ready_i = 1'b0;
      for (int i = 0; i < 10 && gnt_addr_q.size() < 1; i++) tick();
      auto_mem = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
      tick();
      #1;
      n_checks++; if (imem_req_o !== 1'b1 || id_valid_o !== 1'b1 || imem_addr_o !== 32'h44) begin n_fail++; $display("FAIL ar_pre: got req=%b v=%b addr=%h expected req=1 v=1 addr=44", imem_req_o, id_valid_o, imem_addr_o); end
      #2;
      rst_i = 1'b1;
      #1;
      n_checks++; if (imem_req_o !== 1'b0 || id_valid_o !== 1'b0 || pc_hold_o !== 1'b1 || id_inst_o !== NOP) begin n_fail++; $display("FAIL ar_immediate: got req=%b v=%b hold=%b inst=%h expected req=0 v=0 hold=1 inst=%h", imem_req_o, id_valid_o, pc_hold_o, id_inst_o, NOP); end
      tick();
      rst_i = 1'b0;
      auto_mem = 1'b1; id_ready_i = 1'b1;
      clear_logs();
      for (int i = 0; i < 10 && gnt_addr_q.size() < 1; i++) tick();
      n_checks++; if (gnt_addr_q.size() < 1) begin n_fail++; $display("FAIL ar_refetch_timeout: got 0 fetches expected 1"); end
      else begin
         n_checks++; if (gnt_addr_q[0] !== 32'h0) begin n_fail++; $display("FAIL ar_refetch_addr: got %h expected 0", gnt_addr_q[0]); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_zero_wait();
      test_backpressure();
      test_gnt_delay();
      test_redirect_rsp();
      test_redirect_full();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
